// File: rtl/node_launcher.sv
// node_launcher
//   Initiator side of the tree-node ST/RD handshake. A rising edge on GO
//   launches one child computation: C_ST is raised and held until the child
//   acknowledges by dropping C_RD, then the block waits for C_RD to rise
//   again, latches C_RES into DATA and pulses DONE for one cycle.
//
// Optional feature (macro TIMEOUT_EN):
//   Defined   - a saturating cycle counter bounds the acknowledge wait
//               (ACK_LIMIT) and the result wait (DONE_LIMIT). On expiry C_ST
//               drops, the block returns to idle and the sticky TOUT flag is
//               set. DATA is not written and DONE does not pulse. TOUT clears
//               on reset or on the next successful capture.
//   Undefined - both waits are unbounded, TOUT is tied low and the counter
//               does not exist.
//
// Ports:
//   CLK    in          clock, all state changes on posedge
//   RST    in          asynchronous reset, active low
//   GO     in          upstream start request, rising-edge sensitive
//   BUSY   out         high while a launch is in progress
//   DONE   out         one-cycle pulse when DATA has been updated
//   TOUT   out         sticky timeout flag (TIMEOUT_EN builds only)
//   DATA   out [WIDTH] last captured child result
//   C_ST   out         start strobe to the child node
//   C_RD   in          child ready (1 = idle/done, 0 = computing)
//   C_RES  in  [WIDTH] child result

module node_launcher #(
  parameter int WIDTH      = 16,
  parameter int CNT_W      = 8,
  parameter int ACK_LIMIT  = 8,
  parameter int DONE_LIMIT = 200
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             GO,
  output logic             BUSY,
  output logic             DONE,
  output logic             TOUT,
  output logic [WIDTH-1:0] DATA,
  output logic             C_ST,
  input  logic             C_RD,
  input  logic [WIDTH-1:0] C_RES
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] ASSERT    = 2'd1;
  localparam logic [1:0] WAIT_DONE = 2'd2;
  localparam logic [1:0] CAPTURE   = 2'd3;

  // Both limits are compared against a CNT_W-bit counter, so they must fit.
  if (ACK_LIMIT >= (1 << CNT_W) || DONE_LIMIT >= (1 << CNT_W)) begin : g_limit_check
    $error("node_launcher: ACK_LIMIT/DONE_LIMIT do not fit in CNT_W bits");
  end

  logic [1:0] state;
  logic       go_old;
  logic       start;
  logic       ack_to;
  logic       done_to;

  // go_old resets high so a GO level held through reset is not a launch.
  assign start = GO & ~go_old;

`ifdef TIMEOUT_EN
  localparam logic [CNT_W-1:0] ACK_LIM_C  = CNT_W'(ACK_LIMIT);
  localparam logic [CNT_W-1:0] DONE_LIM_C = CNT_W'(DONE_LIMIT);

  logic [CNT_W-1:0] cnt;
  logic             tout;

  // Saturating increment: the counter parks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign ack_to  = (state == ASSERT)    && (cnt == ACK_LIM_C);
  assign done_to = (state == WAIT_DONE) && (cnt == DONE_LIM_C);
  assign TOUT    = tout;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt  <= '0;
      tout <= 1'b0;
    end else begin
      case (state)
        ASSERT: begin
          if (!C_RD) cnt <= '0;           // acknowledge restarts the count
          else       cnt <= sat_inc(cnt);
          if (C_RD && ack_to) tout <= 1'b1;
        end
        WAIT_DONE: begin
          cnt <= sat_inc(cnt);
          if (C_RD)         tout <= 1'b0; // successful capture clears it
          else if (done_to) tout <= 1'b1;
        end
        default: cnt <= '0;
      endcase
    end
  end
`else
  assign ack_to  = 1'b0;
  assign done_to = 1'b0;
  assign TOUT    = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state  <= IDLE;
      go_old <= 1'b1;
      C_ST   <= 1'b0;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
      DATA   <= '0;
    end else begin
      go_old <= GO;
      DONE   <= 1'b0;
      case (state)
        IDLE: begin
          // A child that is already busy cannot be launched; drop the edge.
          if (start && C_RD) begin
            state <= ASSERT;
            C_ST  <= 1'b1;
            BUSY  <= 1'b1;
          end
        end
        ASSERT: begin
          // Only a low C_RD counts as acknowledge; highs are ignored.
          if (!C_RD) begin
            state <= WAIT_DONE;
            C_ST  <= 1'b0;
          end else if (ack_to) begin
            state <= IDLE;
            C_ST  <= 1'b0;
            BUSY  <= 1'b0;
          end
        end
        WAIT_DONE: begin
          if (C_RD) begin
            state <= CAPTURE;
            DATA  <= C_RES;
            DONE  <= 1'b1;
            BUSY  <= 1'b0;
          end else if (done_to) begin
            state <= IDLE;
            BUSY  <= 1'b0;
          end
        end
        // DONE is high for this cycle; GO edges here are dropped.
        CAPTURE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/node_launcher.md
Name: node_launcher

Overview:
- Initiator side of the tree-node ST/RD handshake.
- On an upstream start request, the block raises ST to one child computation node and waits for the child to drop RD (acknowledge) and then raise RD again (result ready).
- It then latches the child's RES and reports completion upstream.
- It sits between the tree scheduler and each leaf or intermediate node, so the scheduler never handles raw ST/RD timing.

Parameters:
- WIDTH, 16, data width of child RES and of DATA.
- CNT_W, 8, width of the timeout counter.
- ACK_LIMIT, 8, maximum cycles to wait for child RD to fall after C_ST rises.
- DONE_LIMIT, 200, maximum cycles to wait for child RD to rise after acknowledge.

Ports:
- CLK  in  1  clock; all state changes on posedge.
- RST  in  1  asynchronous, active-low reset.
- GO  in  1  upstream start request; rising edge sensitive.
- BUSY  out  1  high while a launch is in progress.
- DONE  out  1  one-cycle pulse when DATA has been updated.
- TOUT  out  1  sticky timeout flag (only driven when TIMEOUT_EN is defined).
- DATA  out  WIDTH  last captured child result.
- C_ST  out  1  start strobe to the child node.
- C_RD  in  1  ready from the child node (1 = idle/done, 0 = computing).
- C_RES  in  WIDTH  result from the child node.

Behaviour:
- Reset (RST=0, asynchronous):
  - State IDLE; C_ST=0, BUSY=0, DONE=0, TOUT=0, DATA=0, counter=0.
  - GOold=1, so a GO held high through reset does not launch.
- GO edge detect: GOold is a register of GO; start = GO & ~GOold, evaluated every cycle.
- States:
  - IDLE:
    - DONE=0.
    - If start and C_RD=1: next state ASSERT, C_ST=1, BUSY=1.
    - If start and C_RD=0 (child already busy): request ignored, stay IDLE.
  - ASSERT:
    - C_ST held 1; counter increments.
    - C_RD=0 → next state WAIT_DONE, C_ST=0, counter cleared.
  - WAIT_DONE:
    - C_ST=0; counter increments.
    - C_RD=1 → next state CAPTURE.
  - CAPTURE:
    - DATA<=C_RES, DONE=1 for exactly this one cycle, BUSY=0.
    - Next state IDLE.
- Latency: GO edge sampled at cycle n → C_ST=1 at n+1. With a child whose RD is low for 2 cycles, DONE asserts at n+5.
- C_ST stays high until the acknowledge is seen, so the child always observes a clean 0→1 edge. C_ST is low for at least 2 cycles between launches.
- GO edges while BUSY=1 are dropped, not queued.
- C_RD glitching high during ASSERT has no effect; only C_RD=0 advances.
- DATA holds its value between captures and is never written on a timeout.
- Reset mid-operation: C_ST drops immediately (asynchronous); the child is left to finish on its own.
- Counter saturates at its maximum value and never wraps.

Optional Feature:
- Macro TIMEOUT_EN.
- Defined:
  - In ASSERT, counter==ACK_LIMIT → TOUT=1, C_ST=0, return to IDLE. No DONE pulse, DATA unchanged.
  - In WAIT_DONE, counter==DONE_LIMIT → same handling.
  - TOUT is sticky and cleared only by reset or by the next successful CAPTURE.
- Undefined:
  - The block waits indefinitely in ASSERT and WAIT_DONE.
  - TOUT is tied to 0 and the counter logic is removed.

Test Plan:
- Basic launch: reset, GO 0→1 at cycle 10, child model drops RD at cycle 12, raises it at 14 with RES=16'h1234 → C_ST high for cycles 11–12, DONE pulse at 15, DATA=16'h1234, BUSY low at 15.
- GO held high through reset release, no further edge → C_ST never rises, BUSY stays 0.
- Second GO edge during WAIT_DONE → ignored; exactly one DONE pulse; next launch after IDLE captures a new RES=16'h00FF.
- Child RD already 0 when GO rises → no C_ST; after RD returns to 1, a new GO edge launches normally.
- TIMEOUT_EN, child never drops RD → C_ST falls and TOUT=1 after ACK_LIMIT=8 cycles in ASSERT; DONE never pulses; DATA keeps 16'h1234. A subsequent successful launch clears TOUT.
- RST pulled low while in WAIT_DONE → C_ST, BUSY, DONE, DATA all 0 immediately, without waiting for a clock edge.
